// File: rtl/radiant_event_pkg.sv
// Shared constants and types for the radiant event stamper: header layout,
// flags bit positions and serializer state encoding.
package radiant_event_pkg;

  localparam logic [31:0] HDR_IDENT     = 32'h52444530;
  localparam int          NUM_HDR_WORDS = 8;

  localparam logic [2:0] HDR_W_IDENT    = 3'd0;
  localparam logic [2:0] HDR_W_SEC      = 3'd1;
  localparam logic [2:0] HDR_W_EVCNT    = 3'd2;
  localparam logic [2:0] HDR_W_CLK      = 3'd3;
  localparam logic [2:0] HDR_W_INFO     = 3'd4;
  localparam logic [2:0] HDR_W_FLAGS    = 3'd5;
  localparam logic [2:0] HDR_W_LASTPPS  = 3'd6;
  localparam logic [2:0] HDR_W_LASTLAST = 3'd7;

  localparam int FLG_ROLL_EV  = 0;
  localparam int FLG_ROLL_SEC = 1;
  localparam int FLG_ROLL_CLK = 2;
  localparam int FLG_SRC_LSB  = 3;
  localparam int FLG_SRC_W    = 13;
  localparam int FLG_DROP_LSB = 16;
  localparam int FLG_OVF      = 31;

  // Dynamic header words 1..7; word 0 is the constant identifier.
  typedef struct packed {
    logic [31:0] lastlast;
    logic [31:0] lastpps;
    logic [31:0] flags;
    logic [31:0] info;
    logic [31:0] clk;
    logic [31:0] evcnt;
    logic [31:0] sec;
  } hdr_entry_t;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/radiant_hdr_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop and a push in the same cycle
// are both honoured even when full, and clear_i empties it in one cycle.
module radiant_hdr_sync_fifo #(
  parameter int WIDTH = 224,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push && !clear_i) r_mem[r_wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/radiant_event_stamper.sv
// PPS/clock/event counters with event stamping into a header FIFO, emitted as
// 8-word valid/ready headers; drops are counted when the FIFO is full.
module radiant_event_stamper #(
  parameter int          CNT_WIDTH    = 48,
  parameter int          NSRC         = 4,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] HDR_IDENT    = radiant_event_pkg::HDR_IDENT,
  // Reset value of clk_cnt; nonzero only to reach the 32-bit roll in simulation.
  parameter logic [63:0] CLK_CNT_INIT = 64'd0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          pps_i,
  input  logic                          sync_arm_i,
  input  logic                          fifo_clear_i,
  input  logic [NSRC-1:0]               event_i,
  input  logic [31:0]                   event_info_i,
  output logic [31:0]                   hdr_dat_o,
  output logic                          hdr_valid_o,
  output logic                          hdr_last_o,
  input  logic                          hdr_ready_i,
  output logic                          sync_armed_o,
  output logic                          sync_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o,
  output logic                          overflow_o,
  output logic [31:0]                   sec_count_o
);
  import radiant_event_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  r_sec, r_clk, r_ev;
  logic [CNT_WIDTH-1:32] r_up_sec, r_up_clk, r_up_ev;
  logic [31:0]           r_lastpps, r_lastlast;
  logic                  r_armed, r_sync, r_ovf;
  logic [7:0]            r_drop;
  ser_state_e            r_state;
  logic [2:0]            r_idx;
  logic                  r_valid, r_last;

  logic        w_event, w_sync_go, w_pop, w_accept, w_full, w_empty;
  logic [31:0] w_flags, w_dat;
  hdr_entry_t  w_entry, w_head;

  assign w_event   = |event_i;
  assign w_sync_go = pps_i && r_armed;
  assign w_pop     = r_valid && hdr_ready_i && (r_idx == HDR_W_LASTLAST);
  // The pop is resolved first, so a full FIFO still takes the event.
  assign w_accept  = w_event && !fifo_clear_i && (!w_full || w_pop);

  always_comb begin
    w_flags = '0;
    w_flags[FLG_OVF]                  = r_ovf;
    w_flags[FLG_DROP_LSB +: 8]        = r_drop;
    w_flags[FLG_SRC_LSB +: FLG_SRC_W] = FLG_SRC_W'(event_i);
    w_flags[FLG_ROLL_CLK]             = (r_clk[CNT_WIDTH-1:32] != r_up_clk);
    w_flags[FLG_ROLL_SEC]             = (r_sec[CNT_WIDTH-1:32] != r_up_sec);
    w_flags[FLG_ROLL_EV]              = (r_ev[CNT_WIDTH-1:32]  != r_up_ev);
  end

  assign w_entry = '{lastlast: r_lastlast, lastpps: r_lastpps, flags: w_flags,
                     info: event_info_i, clk: r_clk[31:0], evcnt: r_ev[31:0],
                     sec: r_sec[31:0]};

  radiant_hdr_sync_fifo #(
    .WIDTH ($bits(hdr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (fifo_clear_i),
    .push_i  (w_accept),
    .wdata_i (w_entry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .count_o (pending_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sec      <= '0;
      r_clk      <= CLK_CNT_INIT[CNT_WIDTH-1:0];
      r_ev       <= '0;
      r_lastpps  <= '0;
      r_lastlast <= '0;
      r_armed    <= 1'b0;
      r_sync     <= 1'b0;
    end else begin
      r_sync <= w_sync_go;
      if (w_sync_go) begin
        r_sec      <= '0;
        r_clk      <= '0;
        r_ev       <= '0;
        r_lastpps  <= '0;
        r_lastlast <= '0;
        r_armed    <= 1'b0;
      end else begin
        r_clk <= r_clk + CNT_ONE;
        if (w_event) r_ev <= r_ev + CNT_ONE;
        if (pps_i) begin
          r_sec      <= r_sec + CNT_ONE;
          r_lastpps  <= r_clk[31:0];
          r_lastlast <= r_lastpps;
        end
        if (sync_arm_i) r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || fifo_clear_i) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_accept) begin
      r_drop <= '0;
    end else if (w_event) begin
      r_ovf  <= 1'b1;
      if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_up_sec <= '0;
      r_up_clk <= '0;
      r_up_ev  <= '0;
    end else if (w_accept) begin
      r_up_sec <= r_sec[CNT_WIDTH-1:32];
      r_up_clk <= r_clk[CNT_WIDTH-1:32];
      r_up_ev  <= r_ev[CNT_WIDTH-1:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || fifo_clear_i) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (!w_empty) begin
            r_state <= SER_SEND;
            r_idx   <= HDR_W_IDENT;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        SER_SEND: begin
          if (hdr_ready_i) begin
            if (r_idx == HDR_W_LASTLAST) begin
              r_state <= SER_IDLE;
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_last <= (r_idx == HDR_W_LASTPPS);
            end
          end
        end
        default: r_state <= SER_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dat = HDR_IDENT;
    case (r_idx)
      HDR_W_SEC:      w_dat = w_head.sec;
      HDR_W_EVCNT:    w_dat = w_head.evcnt;
      HDR_W_CLK:      w_dat = w_head.clk;
      HDR_W_INFO:     w_dat = w_head.info;
      HDR_W_FLAGS:    w_dat = w_head.flags;
      HDR_W_LASTPPS:  w_dat = w_head.lastpps;
      HDR_W_LASTLAST: w_dat = w_head.lastlast;
      default:        w_dat = HDR_IDENT;
    endcase
  end

  assign hdr_dat_o    = w_dat;
  assign hdr_valid_o  = r_valid;
  assign hdr_last_o   = r_last;
  assign sync_armed_o = r_armed;
  assign sync_o       = r_sync;
  assign overflow_o   = r_ovf;
  assign sec_count_o  = r_sec[31:0];

endmodule

// File: tb/tb_radiant_event_stamper.sv
// Bench for radiant_event_stamper: directed header/sync/drop/clear sequences
// plus random traffic against a transaction-level reference model.
module tb_radiant_event_stamper;
  localparam int          DEPTH = 16;
  localparam logic [31:0] IDENT = 32'h52444530;

  logic        clk = 1'b0;
  logic        rst_n, pps, arm, clr, rdy;
  logic [3:0]  ev, ev2;
  logic [31:0] info;
  logic [31:0] hdr_dat, d2_dat, sec_cnt, d2_sec;
  logic        hdr_valid, hdr_last, armed_o, sync_o, ovf_o;
  logic        d2_valid, d2_last, d2_armed, d2_sync, d2_ovf;
  logic [4:0]  pending, d2_pend;

  always #5 clk = ~clk;

  radiant_event_stamper dut (
    .clk_i(clk), .rst_n_i(rst_n), .pps_i(pps), .sync_arm_i(arm), .fifo_clear_i(clr),
    .event_i(ev), .event_info_i(info), .hdr_dat_o(hdr_dat), .hdr_valid_o(hdr_valid),
    .hdr_last_o(hdr_last), .hdr_ready_i(rdy), .sync_armed_o(armed_o), .sync_o(sync_o),
    .pending_o(pending), .overflow_o(ovf_o), .sec_count_o(sec_cnt)
  );

  radiant_event_stamper #(.CLK_CNT_INIT(64'h0000_0000_FFFF_FFFD)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .pps_i(1'b0), .sync_arm_i(1'b0), .fifo_clear_i(clr),
    .event_i(ev2), .event_info_i(info), .hdr_dat_o(d2_dat), .hdr_valid_o(d2_valid),
    .hdr_last_o(d2_last), .hdr_ready_i(1'b1), .sync_armed_o(d2_armed), .sync_o(d2_sync),
    .pending_o(d2_pend), .overflow_o(d2_ovf), .sec_count_o(d2_sec)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counters as plain integers, headers as a queue of words.
  typedef struct { logic [31:0] w [8]; } hdr_s;
  hdr_s            q[$];
  logic [31:0]     d2q[$];
  longint unsigned m_sec, m_clk, m_ev, m_up_sec, m_up_clk, m_up_ev;
  logic [31:0]     m_lp, m_llp;
  bit              m_armed, m_sync, m_ovf;
  int              m_drop, widx, cyc, hdr_done;
  logic [31:0]     cur [8];
  logic [31:0]     last_hdr [8];

  task automatic step();
    hdr_s        h;
    logic [31:0] fl;
    if (q.size() == 0) chk("valid_without_entry", hdr_valid, 0);
    if (hdr_valid && rdy && q.size() > 0) begin
      chk($sformatf("hdr_word%0d", widx), hdr_dat, q[0].w[widx]);
      chk($sformatf("hdr_last%0d", widx), hdr_last, widx == 7);
      cur[widx] = hdr_dat;
      if (widx == 7) begin
        last_hdr = cur;
        hdr_done++;
        void'(q.pop_front());
        widx = 0;
      end else widx++;
    end
    if (d2_valid) d2q.push_back(d2_dat);
    if (|ev) begin
      fl = '0;
      fl[31]    = m_ovf;
      fl[23:16] = m_drop[7:0];
      fl[6:3]   = ev;
      fl[2]     = (m_clk >> 32) != m_up_clk;
      fl[1]     = (m_sec >> 32) != m_up_sec;
      fl[0]     = (m_ev >> 32) != m_up_ev;
      if (!clr && q.size() < DEPTH) begin
        h.w[0] = IDENT; h.w[1] = m_sec[31:0]; h.w[2] = m_ev[31:0]; h.w[3] = m_clk[31:0];
        h.w[4] = info;  h.w[5] = fl;          h.w[6] = m_lp;       h.w[7] = m_llp;
        q.push_back(h);
        m_drop = 0;
        m_up_sec = m_sec >> 32; m_up_clk = m_clk >> 32; m_up_ev = m_ev >> 32;
      end else if (!clr) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (clr) begin
      q.delete(); widx = 0; m_ovf = 0; m_drop = 0;
    end
    if (pps && m_armed) begin
      m_sec = 0; m_clk = 0; m_ev = 0; m_lp = 0; m_llp = 0; m_armed = 0; m_sync = 1;
    end else begin
      m_sync = 0;
      if (|ev) m_ev++;
      if (pps) begin m_llp = m_lp; m_lp = m_clk[31:0]; m_sec++; end
      m_clk++;
      if (arm) m_armed = 1;
    end
    @(posedge clk); #1;
    cyc++;
    ev = '0; ev2 = '0; pps = 0; arm = 0; clr = 0;
    chk("pending", pending, q.size());
    chk("sync", sync_o, m_sync);
    chk("armed", armed_o, m_armed);
    chk("sec", sec_cnt, m_sec[31:0]);
    chk("overflow", ovf_o, m_ovf);
  endtask

  task automatic wait_hdr(input string name);
    int n;
    n = hdr_done;
    for (int i = 0; i < 200 && hdr_done == n; i++) step();
    chk(name, hdr_done > n, 1);
  endtask

  typedef struct { logic rdy; logic vld; logic [31:0] dat; logic last; } vec_t;
  vec_t tab [11];

  initial begin
    tab[0]  = '{1'b1, 1'b0, 32'h0,        1'b0};
    tab[1]  = '{1'b1, 1'b1, IDENT,        1'b0};
    tab[2]  = '{1'b1, 1'b1, 32'h0,        1'b0};
    tab[3]  = '{1'b0, 1'b1, 32'h0,        1'b0};
    tab[4]  = '{1'b1, 1'b1, 32'h0,        1'b0};
    tab[5]  = '{1'b1, 1'b1, 32'd10,       1'b0};
    tab[6]  = '{1'b1, 1'b1, 32'hCAFE0001, 1'b0};
    tab[7]  = '{1'b1, 1'b1, 32'h00000008, 1'b0};
    tab[8]  = '{1'b1, 1'b1, 32'h0,        1'b0};
    tab[9]  = '{1'b1, 1'b1, 32'h0,        1'b1};
    tab[10] = '{1'b1, 1'b0, 32'h0,        1'b0};

    rst_n = 0; pps = 0; arm = 0; clr = 0; rdy = 1; ev = '0; ev2 = '0; info = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", hdr_valid, 0);
    chk("rst_last", hdr_last, 0);
    chk("rst_sync", sync_o, 0);
    chk("rst_armed", armed_o, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", ovf_o, 0);
    chk("rst_sec", sec_cnt, 0);
    m_sec = 0; m_clk = 0; m_ev = 0; m_up_sec = 0; m_up_clk = 0; m_up_ev = 0;
    m_lp = 0; m_llp = 0; m_armed = 0; m_sync = 0; m_ovf = 0; m_drop = 0;
    widx = 0; cyc = 0; hdr_done = 0;
    rst_n = 1;

    // First header after reset, with one stall cycle on word 2.
    while (cyc < 10) begin
      if (cyc == 4) ev2 = 4'b0001;
      step();
    end
    ev = 4'b0001; info = 32'hCAFE0001;
    step();
    for (int i = 0; i < 11; i++) begin
      rdy = tab[i].rdy;
      chk($sformatf("tab%0d_valid", i), hdr_valid, tab[i].vld);
      if (tab[i].vld) begin
        chk($sformatf("tab%0d_dat", i), hdr_dat, tab[i].dat);
        chk($sformatf("tab%0d_last", i), hdr_last, tab[i].last);
      end
      step();
    end
    rdy = 1;

    // clk_cnt crossing 2^32 on the preloaded instance.
    while (cyc < 30) step();
    ev2 = 4'b0001;
    step();
    while (cyc < 45) step();
    chk("roll_hdr_words", d2q.size(), 16);
    if (d2q.size() == 16) begin
      chk("roll1_clk", d2q[3], 32'd1);
      chk("roll1_flags", d2q[5], 32'h0000000C);
      chk("roll1_evcnt", d2q[2], 32'd0);
      chk("roll2_clk", d2q[11], 32'd27);
      chk("roll2_flags", d2q[13], 32'h00000008);
      chk("roll2_evcnt", d2q[10], 32'd1);
    end

    // Plain PPS, then a multi-source event.
    pps = 1;
    step();
    while (cyc < 48) step();
    ev = 4'b1010; info = $urandom;
    step();
    wait_hdr("multi_src_wait");
    chk("multi_src_mask", last_hdr[5][6:3], 4'b1010);
    chk("multi_src_evcnt", last_hdr[2], 32'd1);
    chk("multi_src_lastpps", last_hdr[6], 32'd45);

    // Armed sync, then an event five cycles after the PPS.
    while (cyc < 60) step();
    arm = 1;
    step();
    chk("armed_set", armed_o, 1);
    while (cyc < 160) step();
    pps = 1;
    step();
    chk("sync_pulse", sync_o, 1);
    while (cyc < 165) step();
    ev = 4'b0001; info = 32'h5A5A0000;
    step();
    wait_hdr("sync_hdr_wait");
    chk("sync_hdr_sec", last_hdr[1], 32'd0);
    chk("sync_hdr_clk", last_hdr[3], 32'd4);
    chk("sync_hdr_evcnt", last_hdr[2], 32'd0);
    chk("sync_hdr_lastpps", last_hdr[6], 32'd0);

    // Arm coinciding with PPS: that PPS counts a second, the next one syncs.
    while (cyc < 200) step();
    pps = 1; arm = 1;
    step();
    chk("arm_pps_no_sync", sync_o, 0);
    chk("arm_pps_sec", sec_cnt, 32'd1);
    while (cyc < 210) step();
    pps = 1;
    step();
    chk("second_sync", sync_o, 1);
    chk("second_sync_sec", sec_cnt, 32'd0);

    // Overflow: 20 events into a 16-deep FIFO with the consumer stalled.
    while (cyc < 230) step();
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      ev = 4'($urandom_range(1, 15)); info = $urandom;
      step();
    end
    chk("full_pending", pending, 16);
    chk("full_overflow", ovf_o, 1);
    rdy = 1;
    for (int i = 0; i < 1000 && q.size() > 0; i++) step();
    chk("drain_done", q.size(), 0);
    ev = 4'b0001; info = 32'h0D0D0D0D;
    step();
    wait_hdr("drop_hdr_wait");
    chk("drop_hdr_cnt", last_hdr[5][23:16], 8'd4);
    chk("drop_hdr_ovf", last_hdr[5][31], 1);
    chk("drop_hdr_evcnt", last_hdr[2], 32'd20);

    // Clear in the middle of word 3 with three headers pending.
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      ev = 4'b0100; info = $urandom;
      step();
    end
    rdy = 1;
    for (int i = 0; i < 50; i++) begin
      if (hdr_valid && widx == 3) begin
        clr = 1;
        step();
        break;
      end
      step();
    end
    chk("clear_valid", hdr_valid, 0);
    chk("clear_pending", pending, 0);
    chk("clear_overflow", ovf_o, 0);
    ev = 4'b0010; info = 32'h11112222;
    step();
    wait_hdr("post_clear_wait");

    // Event coinciding with the pop of a full FIFO is accepted.
    rdy = 0;
    for (int i = 0; i < 16; i++) begin
      ev = 4'b1000; info = $urandom;
      step();
    end
    rdy = 1;
    for (int i = 0; i < 50; i++) begin
      if (hdr_valid && widx == 7) begin
        ev = 4'b0001; info = 32'hF00DF00D;
        step();
        break;
      end
      step();
    end
    chk("pushpop_pending", pending, 16);
    chk("pushpop_overflow", ovf_o, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rdy  = ($urandom_range(0, 3) != 0);
      ev   = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      info = $urandom;
      pps  = ($urandom_range(0, 249) == 0);
      arm  = !pps && ($urandom_range(0, 399) == 0);
      clr  = ($urandom_range(0, 1499) == 0);
      step();
    end
    rdy = 1;
    for (int i = 0; i < 2000 && (q.size() > 0 || hdr_valid); i++) step();
    chk("final_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radiant_event_stamper.md
Name: radiant_event_stamper

Overview:
Parametrised, single-clock successor to the event timing core. It keeps the PPS second counter, the free-running clock counter and the event counter at configurable width. It accepts NSRC event sources and stamps each accepted event into an on-chip header FIFO of configurable depth. Each header is emitted as an 8-word valid/ready stream to the DMA/readout path, with drop accounting and PPS-aligned sync.

Parameters:
CNT_WIDTH, 48, width of the second, clock and event counters; legal range 33..64.
NSRC, 4, number of event sources; legal range 1..16.
FIFO_DEPTH, 16, header FIFO depth in entries; must be a power of 2 and at least 2.
HDR_IDENT, 32'h52444530, constant header word 0 ("RDE0").

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  reset; synchronous, active-low.
pps_i  in  1  one-cycle PPS pulse, already in the clk_i domain.
sync_arm_i  in  1  pulse; arms a counter clear on the next pps_i.
fifo_clear_i  in  1  pulse; flushes the header FIFO and the drop accounting.
event_i  in  NSRC  per-source event pulses.
event_info_i  in  32  info word, sampled with the event.
hdr_dat_o  out  32  header word.
hdr_valid_o  out  1  hdr_dat_o is valid.
hdr_last_o  out  1  marks word 7 of a header.
hdr_ready_i  in  1  consumer accepts the word.
sync_armed_o  out  1  a sync is armed.
sync_o  out  1  one-cycle pulse; counters are cleared in this cycle.
pending_o  out  $clog2(FIFO_DEPTH)+1  number of headers stored, including the one currently being emitted.
overflow_o  out  1  sticky flag: at least one event was dropped.
sec_count_o  out  32  current second count, bits [31:0].

Behaviour:
- Reset (rst_n_i low at a clk_i edge):
  - All counters, FIFO pointers and flags go to 0; drop_cnt goes to 0.
  - hdr_valid_o=0, hdr_last_o=0, sync_o=0, sync_armed_o=0, pending_o=0.
- PPS handling:
  - pps_i with armed=0: sec<=sec+1; lastpps<=clk_cnt[31:0]; lastlastpps<=lastpps.
  - pps_i with armed=1: next cycle sync_o=1. In that same next cycle sec, clk_cnt, evcnt, lastpps and lastlastpps all read 0, and armed clears.
  - sync_arm_i in the same cycle as pps_i: armed is set, but that pps does not sync.
- clk_cnt increments every cycle except the sync cycle.
- Event capture:
  - An event occurs in cycle t when |event_i is true.
  - Multiple sources in one cycle produce a single header; word 5 carries the source mask.
  - evcnt increments for every event, dropped or not, so gaps in the count reveal drops.
  - The header entry is built from the values in cycle t: sec, evcnt before increment, clk_cnt, event_info_i, flags, lastpps, lastlastpps.
  - The entry is written to the FIFO at t+1.
  - Earliest hdr_valid_o is t+2 when the FIFO was empty and the serializer idle.
- Header words:
  - 0: HDR_IDENT.
  - 1: sec[31:0].
  - 2: evcnt[31:0].
  - 3: clk_cnt[31:0].
  - 4: event_info.
  - 5: flags = {overflow_o, 7'b0, drop_cnt[7:0], src_mask zero-extended to 13 bits, roll_clk, roll_sec, roll_ev}.
  - 6: lastpps.
  - 7: lastlastpps.
  - A roll_x bit is set when counter bits [CNT_WIDTH-1:32] differ from their value at the previous accepted capture.
- Drop rule:
  - An event is dropped if the FIFO is full at t, or if fifo_clear_i is asserted at t.
  - A drop sets overflow_o and increments drop_cnt, saturating at 255.
  - drop_cnt is reported in the next accepted header and is then zeroed. overflow_o stays set.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, go to SEND with word index 0.
  - SEND: a word transfers when hdr_valid_o && hdr_ready_i. The index advances only on a transfer.
  - On word 7 transfer: hdr_last_o=1, the entry is popped, and the FSM goes back to IDLE.
  - If another entry is pending, SEND restarts in the next cycle; one bubble cycle is allowed.
  - hdr_dat_o is stable while valid is high and ready is low.
- fifo_clear_i:
  - Next cycle: FIFO empty, FSM in IDLE, hdr_valid_o=0, pending_o=0, overflow_o=0, drop_cnt=0.
  - A header partway through emission is aborted.
  - Counters and the sync state are unaffected.
- Simultaneous push and pop on a full FIFO: the pop happens first, so the event is accepted.
- pending_o reaches FIFO_DEPTH when the FIFO is full.

Decomposition:
- Package radiant_event_pkg holds:
  - HDR_IDENT and NUM_HDR_WORDS=8;
  - word index constants HDR_W_IDENT..HDR_W_LASTLAST;
  - flags bit positions FLG_ROLL_EV/SEC/CLK, FLG_SRC_LSB, FLG_DROP_LSB, FLG_OVF;
  - serializer state encoding.
- One sub-module: radiant_hdr_sync_fifo. It is a single-clock FIFO, parametrised in width (7x32 dynamic words) and depth, with count, full and empty.

Test Plan:
1. Reset, then event_i=4'b0001 at cycle 10 with event_info_i=32'hCAFE0001 -> header appears from cycle 12: 52444530, 0, 0, 10, CAFE0001, flags=32'h00000008, 0, 0; hdr_last_o on word 7.
2. sync_arm_i, then pps_i 100 cycles later -> sync_o pulses the cycle after pps_i; an event 5 cycles later stamps sec=0 and clk_cnt=4.
3. FIFO_DEPTH=16, hdr_ready_i=0, 20 events -> pending_o=16, overflow_o=1; after drain and one more event, that header has drop_cnt=4 and evcnt=20.
4. event_i=4'b1010 in one cycle -> a single header with src_mask bits[6:3]=1010; evcnt increments by 1.
5. Preload clk_cnt to 2^32-3, event at 2^32+1 -> flags roll_clk=1; the next event has roll_clk=0.
6. fifo_clear_i during word 3 of emission with 3 pending -> next cycle hdr_valid_o=0, pending_o=0, overflow_o=0; sec and clk_cnt continue uninterrupted.
